// File: rtl/missile_pkg.sv
// Shared widths, index types and defaults for the missile launch scheduler slice.
package missile_pkg;

    localparam int unsigned DEFAULT_NUM_REQ         = 4;
    localparam int unsigned DEFAULT_NUM_SLOTS       = 8;
    localparam int unsigned DEFAULT_MAX_PER_REQ     = 3;
    localparam int unsigned DEFAULT_COOLDOWN_W      = 4;
    localparam int unsigned DEFAULT_COOLDOWN_FRAMES = 15;

    // Index width that stays at least one bit for degenerate single-entry pools.
    function automatic int unsigned req_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    typedef logic [req_w(DEFAULT_NUM_REQ)-1:0]    req_idx_t;
    typedef logic [slot_w(DEFAULT_NUM_SLOTS)-1:0] slot_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_arbiter import missile_pkg::*; #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = req_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && req[wrap_idx(ptr, k)]) begin
                any       = 1'b1;
                grant_idx = wrap_idx(ptr, k);
            end
        end
        if (any) grant = N'(1) << grant_idx;
    end

endmodule

// File: rtl/missile_launch_scheduler.sv
// Shares a pool of missile slots among shooters: latches requests, applies cooldown
// and live-missile quota, and launches one missile per cycle into the lowest free slot.
module missile_launch_scheduler import missile_pkg::*; #(
    parameter  int unsigned NUM_REQ         = DEFAULT_NUM_REQ,
    parameter  int unsigned NUM_SLOTS       = DEFAULT_NUM_SLOTS,
    parameter  int unsigned MAX_PER_REQ     = DEFAULT_MAX_PER_REQ,
    parameter  int unsigned COOLDOWN_W      = DEFAULT_COOLDOWN_W,
    parameter  int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
    localparam int unsigned REQ_W           = req_w(NUM_REQ),
    localparam int unsigned SLOT_W          = slot_w(NUM_SLOTS),
    localparam int unsigned CNT_W           = cnt_w(MAX_PER_REQ)
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_REQ-1:0]       shoot_req,
    input  logic [NUM_SLOTS-1:0]     slot_active,
    output logic                     launch_valid,
    output logic [SLOT_W-1:0]        launch_slot,
    output logic [REQ_W-1:0]         launch_owner,
    output logic [NUM_SLOTS-1:0]     launch_onehot,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       cooldown_active,
    output logic [NUM_REQ*CNT_W-1:0] live_count
);

    localparam int unsigned REL_W = cnt_w(NUM_SLOTS);
    localparam int unsigned SUM_W = CNT_W + REL_W;

    logic [NUM_REQ-1:0]                  pending_q, pending_d;
    logic [NUM_REQ-1:0][COOLDOWN_W-1:0]  cooldown_q, cooldown_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]       live_q, live_d;
    logic [NUM_SLOTS-1:0]                reserved_q, reserved_d;
    logic [NUM_SLOTS-1:0]                owned_q, owned_d;
    logic [NUM_SLOTS-1:0]                active_q;
    logic [NUM_SLOTS-1:0][REQ_W-1:0]     owner_q, owner_d;
    logic [REQ_W-1:0]                    ptr_q, ptr_d;

    logic [NUM_SLOTS-1:0]                free_c, release_c;
    logic [SLOT_W-1:0]                   free_idx_c;
    logic                                any_free_c;
    logic [NUM_REQ-1:0]                  eligible_c, win_onehot_c;
    logic [REQ_W-1:0]                    win_idx_c;
    logic                                win_c;
    logic [NUM_REQ-1:0][REL_W-1:0]       rel_cnt_c;

    // Lowest free slot: neither flying nor awaiting the pool's activation.
    always_comb begin
        free_c     = ~slot_active & ~reserved_q;
        any_free_c = |free_c;
        free_idx_c = '0;
        for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
            if (free_c[s]) free_idx_c = SLOT_W'(s);
        end
    end

    always_comb begin
        eligible_c = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            eligible_c[r] = pending_q[r] && (32'(live_q[r]) < MAX_PER_REQ) && any_free_c;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (eligible_c),
        .ptr       (ptr_q),
        .grant     (win_onehot_c),
        .grant_idx (win_idx_c),
        .any       (win_c)
    );

    // Falling edges on tracked slots return missiles to their owners' quota.
    always_comb begin
        release_c = owned_q & active_q & ~slot_active;
        rel_cnt_c = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (release_c[s]) rel_cnt_c[owner_q[s]] = rel_cnt_c[owner_q[s]] + REL_W'(1);
        end
    end

    always_comb begin
        pending_d  = pending_q;
        cooldown_d = cooldown_q;
        live_d     = live_q;
        reserved_d = reserved_q;
        owned_d    = owned_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;

        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            // A grant reloads cooldown, which also swallows a same-cycle request.
            if (win_onehot_c[r]) begin
                pending_d[r]  = 1'b0;
                cooldown_d[r] = COOLDOWN_W'(COOLDOWN_FRAMES);
            end else begin
                if (shoot_req[r] && cooldown_q[r] == '0) pending_d[r] = 1'b1;
                if (startOfFrame && cooldown_q[r] != '0) cooldown_d[r] = cooldown_q[r] - COOLDOWN_W'(1);
            end
            live_d[r] = CNT_W'(SUM_W'(live_q[r]) + SUM_W'(win_onehot_c[r]) - SUM_W'(rel_cnt_c[r]));
        end

        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (win_c && free_idx_c == SLOT_W'(s)) begin
                reserved_d[s] = 1'b1;
                owned_d[s]    = 1'b1;
                owner_d[s]    = win_idx_c;
            end else begin
                if (slot_active[s]) reserved_d[s] = 1'b0;
                if (release_c[s])   owned_d[s]    = 1'b0;
            end
        end

        if (win_c) ptr_d = (win_idx_c == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx_c + REQ_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending_q       <= '0;
            cooldown_q      <= '0;
            live_q          <= '0;
            reserved_q      <= '0;
            owned_q         <= '0;
            active_q        <= '0;
            owner_q         <= '0;
            ptr_q           <= '0;
            launch_valid    <= 1'b0;
            launch_slot     <= '0;
            launch_owner    <= '0;
            launch_onehot   <= '0;
            req_grant       <= '0;
            cooldown_active <= '0;
        end else begin
            pending_q     <= pending_d;
            cooldown_q    <= cooldown_d;
            live_q        <= live_d;
            reserved_q    <= reserved_d;
            owned_q       <= owned_d;
            active_q      <= slot_active;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            launch_valid  <= win_c;
            launch_slot   <= win_c ? free_idx_c : '0;
            launch_owner  <= win_c ? win_idx_c : '0;
            launch_onehot <= win_c ? (NUM_SLOTS'(1) << free_idx_c) : '0;
            req_grant     <= win_onehot_c;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                cooldown_active[r] <= |cooldown_d[r];
            end
        end
    end

    assign live_count = live_q;

endmodule
